// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Two-requester, frame-locked arbiter in front of a single UART transmitter.
//   A requester presents bytes (req/data/last). Once granted, it owns the UART
//   until the byte flagged "last" has been handed over. Contests between both
//   requesters are resolved round-robin at frame granularity.
//
//   Optional feature: define UART_ARB_TIMEOUT_EN to abort a frame whose owner
//   leaves req low in LOAD for TIMEOUT_CYCLES consecutive cycles. Without the
//   macro, LOAD waits indefinitely and frame_abort is tied low.
//
// Ports
//   clock             : single clock, rising edge
//   reset             : asynchronous, active-high
//   req0/req1         : requester has a byte presented
//   data0/data1       : presented byte (valid while reqN high)
//   last0/last1       : presented byte ends the frame
//   ack0/ack1         : one-cycle pulse when the byte is taken
//   gnt               : one-hot owner of the UART, 00 when idle
//   uart_ready        : transmitter idle when high
//   uart_data         : byte handed to the transmitter
//   uart_clock_enable : load strobe, held until the transmitter goes busy
//   frame_abort       : one-cycle pulse on stall-timeout abort
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic [1:0] gnt,
  input  logic       uart_ready,
  output logic [7:0] uart_data,
  output logic       uart_clock_enable,
  output logic       frame_abort
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] gnt_reg, gnt_next;
  // Index of the requester that owned the last finished frame.
  logic       rr_reg, rr_next;
  logic [7:0] data_reg, data_next;
  logic       uce_reg, uce_next;
  logic       last_reg, last_next;
  logic [1:0] ack_reg, ack_next;

  // Inputs of the current owner; the other port is never looked at.
  logic       sel_req;
  logic [7:0] sel_data;
  logic       sel_last;

  assign sel_req  = gnt_reg[1] ? req1  : req0;
  assign sel_data = gnt_reg[1] ? data1 : data0;
  assign sel_last = gnt_reg[1] ? last1 : last0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          abort_reg, abort_next;
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    rr_next    = rr_reg;
    data_next  = data_reg;
    uce_next   = uce_reg;
    last_next  = last_reg;
    ack_next   = 2'b00;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_next   = '0;
    abort_next = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (req0 && req1) begin
          // Contest: whoever did not finish the last frame wins.
          gnt_next   = rr_reg ? 2'b01 : 2'b10;
          state_next = LOAD;
        end else if (req0) begin
          gnt_next   = 2'b01;
          state_next = LOAD;
        end else if (req1) begin
          gnt_next   = 2'b10;
          state_next = LOAD;
        end
      end

      LOAD: begin
        if (sel_req && uart_ready) begin
          data_next  = sel_data;
          last_next  = sel_last;
          ack_next   = gnt_reg;
          uce_next   = 1'b1;
          state_next = WAIT_BUSY;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!sel_req) begin
          if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
            abort_next = 1'b1;
            gnt_next   = 2'b00;
            rr_next    = gnt_reg[1];
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
`endif
      end

      WAIT_BUSY: begin
        // The transmitter signals it took the byte by dropping uart_ready.
        if (!uart_ready) begin
          uce_next = 1'b0;
          if (last_reg) begin
            gnt_next   = 2'b00;
            rr_next    = gnt_reg[1];
            state_next = IDLE;
          end else begin
            state_next = LOAD;
          end
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = 2'b00;
        uce_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= 2'b00;
      rr_reg    <= 1'b1;   // requester 0 wins the first contest
      data_reg  <= 8'h00;
      uce_reg   <= 1'b0;
      last_reg  <= 1'b0;
      ack_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      rr_reg    <= rr_next;
      data_reg  <= data_next;
      uce_reg   <= uce_next;
      last_reg  <= last_next;
      ack_reg   <= ack_next;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      abort_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      abort_reg <= abort_next;
    end
  end

  assign frame_abort = abort_reg;
`else
  assign frame_abort = 1'b0;
`endif

  assign gnt               = gnt_reg;
  assign ack0              = ack_reg[0];
  assign ack1              = ack_reg[1];
  assign uart_data         = data_reg;
  assign uart_clock_enable = uce_reg;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: consecutive cycles a granted requester may hold req low mid-frame before abort.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports req0/req1, input, 1 each: requester has a byte presented.
REQ-005 SHALL have ports data0/data1, input, 8 each: byte presented, valid while reqN high.
REQ-006 SHALL have ports last0/last1, input, 1 each: presented byte ends the frame.
REQ-007 SHALL have ports ack0/ack1, output, 1 each: one-cycle pulse when the byte is taken.
REQ-008 SHALL have port gnt, output, 2: one-hot owner of the UART; 00 when idle.
REQ-009 SHALL have port uart_ready, input, 1: transmitter idle when high.
REQ-010 SHALL have ports uart_data (output, 8) and uart_clock_enable (output, 1): byte and load strobe to the transmitter.
REQ-011 SHALL have port frame_abort, output, 1: one-cycle pulse on timeout abort.

Function
REQ-012 SHALL implement states IDLE, LOAD, WAIT_BUSY.
REQ-013 IDLE: if any reqN high, SHALL set gnt and go to LOAD next cycle; both high -> grant the requester not granted last (round-robin pointer).
REQ-014 LOAD: when granted reqN and uart_ready both high, SHALL latch dataN into uart_data, latch lastN, pulse ackN, assert uart_clock_enable, go to WAIT_BUSY, in the same edge.
REQ-015 WAIT_BUSY: SHALL hold uart_clock_enable and uart_data until uart_ready low; then deassert uart_clock_enable and go to IDLE if latched last was 1, else LOAD.
REQ-016 On frame completion SHALL clear gnt to 00 and set round-robin pointer to the finished requester.
REQ-017 Grant SHALL be frame-locked: the non-granted requester is never acked mid-frame regardless of its req.
REQ-018 The data/last/ack of the non-granted port SHALL be ignored; ackN of the non-granted port SHALL stay 0.
REQ-019 Minimum byte cost SHALL be 2 cycles plus the uart_ready low wait; at most one ack per byte sent.
REQ-020 reqN dropping after grant but before its first byte SHALL be treated as a mid-frame stall, per REQ-026/027.

Reset
REQ-021 While reset high SHALL force state IDLE, gnt=00, ack0=ack1=0, uart_clock_enable=0, uart_data=8'h00, frame_abort=0, timeout counter 0.
REQ-022 Round-robin pointer SHALL reset to requester 1 so requester 0 wins the first contest.
REQ-023 Reset asserted mid-byte SHALL drop uart_clock_enable immediately (asynchronously); the partial frame is discarded, no ack issued.

Configuration
REQ-024 Macro UART_ARB_TIMEOUT_EN SHALL control the mid-frame stall timeout.
REQ-025 With UART_ARB_TIMEOUT_EN defined: a counter SHALL count consecutive LOAD cycles with granted req low, clearing on req high.
REQ-026 With the macro defined: at count TIMEOUT_CYCLES-1 SHALL pulse frame_abort, clear gnt, update round-robin pointer, return to IDLE.
REQ-027 Without the macro: LOAD SHALL wait indefinitely; frame_abort tied 0; no counter logic.

Verification
REQ-028 Reset, req0=1 data0=8'h41 last0=1, uart_ready=1 -> gnt=01, ack0 one pulse, uart_data=8'h41, enable held until uart_ready low, then gnt=00.
REQ-029 req0 and req1 asserted same cycle after reset, 1-byte frames each -> requester 0 sent first, then requester 1; repeat -> order 0,1 again.
REQ-030 Requester 0 sends 3-byte frame (8'h10,8'h11,8'h12 last) while req1 high throughout -> bytes 10,11,12 contiguous, no ack1 until gnt cleared.
REQ-031 Macro defined, TIMEOUT_CYCLES=16, req0 drops after first byte -> frame_abort pulses exactly 16 cycles after req0 low, gnt=00; macro undefined -> gnt stays 01.
REQ-032 Reset pulsed while uart_clock_enable=1 -> enable 0 same cycle, gnt=00, next req1-only frame granted normally.
